// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command FIFO feeding an external fixed-latency ALU, with a
// valid/op pipe that tracks in-flight operations and a result FIFO that
// collects ALU results in issue order. Issue is throttled so that every
// in-flight operation is guaranteed a free result slot on capture.
module alu_cmd_seq #(
  parameter int WIDTH   = 16,
  parameter int CDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op
);

  localparam int CAW = $clog2(CDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam logic [CAW:0] CDEPTH_C = (CAW+1)'(CDEPTH);

  // Command FIFO storage and bookkeeping
  logic [2:0]       cmd_op_mem [CDEPTH];
  logic [WIDTH-1:0] cmd_a_mem  [CDEPTH];
  logic [WIDTH-1:0] cmd_b_mem  [CDEPTH];
  logic [CAW-1:0]   cmd_wr_ptr_q, cmd_wr_ptr_d;
  logic [CAW-1:0]   cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CAW:0]     cmd_count_q, cmd_count_d;

  // Result FIFO storage and bookkeeping
  logic [WIDTH-1:0] res_data_mem [RDEPTH];
  logic [2:0]       res_op_mem   [RDEPTH];
  logic [RAW-1:0]   res_wr_ptr_q, res_wr_ptr_d;
  logic [RAW-1:0]   res_rd_ptr_q, res_rd_ptr_d;
  logic [RAW:0]     res_count_q, res_count_d;

  // In-flight tracking pipe: one {valid, op} per ALU latency stage
  logic [LATENCY-1:0] pv_q;
  logic [2:0]         pop_q [LATENCY];

  logic        accept;
  logic        issue;
  logic        capture;
  logic        pop;
  logic [31:0] inflight;
  logic [31:0] occupancy;

  // Handshakes and the issue throttle, all from registered state only
  always_comb begin
    inflight = 32'd0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(pv_q[i]);
    end
    occupancy = inflight + 32'(res_count_q);
    in_ready  = reset && (cmd_count_q < CDEPTH_C);
    accept    = in_valid && in_ready;
    issue     = reset && (cmd_count_q != '0) && (occupancy < 32'(RDEPTH));
    capture   = pv_q[LATENCY-1];
    out_valid = reset && (res_count_q != '0);
    pop       = out_valid && out_ready;
  end

  // Drive the ALU with the FIFO head only while an issue is happening
  always_comb begin
    alu_op = 3'd0;
    alu_a  = '0;
    alu_b  = '0;
    if (issue) begin
      alu_op = cmd_op_mem[cmd_rd_ptr_q];
      alu_a  = cmd_a_mem[cmd_rd_ptr_q];
      alu_b  = cmd_b_mem[cmd_rd_ptr_q];
    end
  end

  // Present the oldest buffered result, zero when the buffer is empty
  always_comb begin
    out_data = '0;
    out_op   = 3'd0;
    if (out_valid) begin
      out_data = res_data_mem[res_rd_ptr_q];
      out_op   = res_op_mem[res_rd_ptr_q];
    end
  end

  // Next-state for both FIFOs' pointers and occupancy counts
  always_comb begin
    cmd_wr_ptr_d = cmd_wr_ptr_q;
    cmd_rd_ptr_d = cmd_rd_ptr_q;
    cmd_count_d  = cmd_count_q;
    res_wr_ptr_d = res_wr_ptr_q;
    res_rd_ptr_d = res_rd_ptr_q;
    res_count_d  = res_count_q;
    if (accept) cmd_wr_ptr_d = CAW'(cmd_wr_ptr_q + 1'b1);
    if (issue)  cmd_rd_ptr_d = CAW'(cmd_rd_ptr_q + 1'b1);
    if (accept && !issue) cmd_count_d = cmd_count_q + 1'b1;
    else if (!accept && issue) cmd_count_d = cmd_count_q - 1'b1;
    if (capture) res_wr_ptr_d = RAW'(res_wr_ptr_q + 1'b1);
    if (pop)     res_rd_ptr_d = RAW'(res_rd_ptr_q + 1'b1);
    if (capture && !pop) res_count_d = res_count_q + 1'b1;
    else if (!capture && pop) res_count_d = res_count_q - 1'b1;
  end

  // Pointer and count registers, cleared by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_count_q  <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_count_q  <= '0;
    end else begin
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      cmd_count_q  <= cmd_count_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      res_count_q  <= res_count_d;
    end
  end

  // FIFO storage writes; contents need no reset since counts gate reads
  always_ff @(posedge clock) begin
    if (accept) begin
      cmd_op_mem[cmd_wr_ptr_q] <= in_op;
      cmd_a_mem[cmd_wr_ptr_q]  <= in_a;
      cmd_b_mem[cmd_wr_ptr_q]  <= in_b;
    end
    if (capture) begin
      res_data_mem[res_wr_ptr_q] <= alu_result;
      res_op_mem[res_wr_ptr_q]   <= pop_q[LATENCY-1];
    end
  end

  // Valid/op pipe shifts every edge; stage 0 loads the op being issued
  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // First stage samples the issue decision and the head op
        always_ff @(posedge clock) begin
          if (!reset) begin
            pv_q[0]  <= 1'b0;
            pop_q[0] <= 3'd0;
          end else begin
            pv_q[0]  <= issue;
            pop_q[0] <= alu_op;
          end
        end
      end else begin : g_tail
        // Later stages follow the previous stage one edge behind
        always_ff @(posedge clock) begin
          if (!reset) begin
            pv_q[gi]  <= 1'b0;
            pop_q[gi] <= 3'd0;
          end else begin
            pv_q[gi]  <= pv_q[gi-1];
            pop_q[gi] <= pop_q[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule
